// File: rtl/pe_array_ctrl.sv
// Sequencer for the convolution PE array: ifmap-group / filter-group loops,
// buffer load handshake and parallel or one-hot PE dispatch. Optional WAIT watchdog under PE_TIMEOUT_EN.
module pe_array_ctrl #(
    parameter int PE_COUNT = 3,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_ifg,
    input  logic [CNT_W-1:0]    num_filtg,
    input  logic                mode,
    input  logic                if_load_done,
    input  logic [PE_COUNT-1:0] pe_done,
    output logic                busy,
    output logic                rst_dp,
    output logic                ifwen,
    output logic                sel_addr,
    output logic [PE_COUNT-1:0] start_pe,
    output logic [PE_COUNT-1:0] pe_sel,
    output logic [CNT_W-1:0]    ifg_idx,
    output logic [CNT_W-1:0]    filtg_idx,
    output logic                mod,
    output logic                done_all,
    output logic                err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLR      = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_DISPATCH = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_ADVANCE  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    generate
        if (PE_COUNT < 1 || TIMEOUT < 1) begin : g_bad_param
            $error("pe_array_ctrl: PE_COUNT and TIMEOUT must be >= 1");
        end
    endgenerate

    // A programmed count of zero runs the loop once, same as a count of one.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(1) : n;
    endfunction

    function automatic logic [PE_COUNT-1:0] first_sel(input logic m);
        return m ? PE_COUNT'(1) : '1;
    endfunction

    logic [2:0]          state;
    logic [CNT_W-1:0]    ifg_cnt;
    logic [CNT_W-1:0]    filtg_cnt;
    logic [PE_COUNT-1:0] done_sticky;
    logic [PE_COUNT-1:0] done_now;
    logic                sel_done;
    logic [CNT_W-1:0]    filtg_next;
    logic [CNT_W-1:0]    ifg_next;
    logic                timeout_hit;

    assign done_now   = done_sticky | pe_done;
    assign sel_done   = ((done_now & pe_sel) == pe_sel);
    assign filtg_next = filtg_idx + CNT_W'(1);
    assign ifg_next   = ifg_idx + CNT_W'(1);

`ifdef PE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ifg_cnt     <= '0;
            filtg_cnt   <= '0;
            ifg_idx     <= '0;
            filtg_idx   <= '0;
            pe_sel      <= '0;
            mod         <= 1'b0;
            done_sticky <= '0;
`ifdef PE_TIMEOUT_EN
            wait_cnt    <= '0;
            err         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ifg_cnt   <= eff_count(num_ifg);
                        filtg_cnt <= eff_count(num_filtg);
                        mod       <= mode;
                        ifg_idx   <= '0;
                        filtg_idx <= '0;
                        pe_sel    <= first_sel(mode);
`ifdef PE_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                        state     <= S_CLR;
                    end
                end
                S_CLR: state <= S_LOAD;
                S_LOAD: begin
                    if (if_load_done) state <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    // Completions seen during the start pulse are stale and dropped here.
                    done_sticky <= done_sticky & ~pe_sel;
`ifdef PE_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    done_sticky <= done_now;
`ifdef PE_TIMEOUT_EN
                    wait_cnt    <= wait_cnt + TO_W'(1);
`endif
                    if (sel_done) begin
                        state <= S_ADVANCE;
                    end else if (timeout_hit) begin
`ifdef PE_TIMEOUT_EN
                        err   <= 1'b1;
`endif
                        state <= S_DONE;
                    end
                end
                S_ADVANCE: begin
                    if (mod && !pe_sel[PE_COUNT-1]) begin
                        pe_sel <= pe_sel << 1;
                        state  <= S_DISPATCH;
                    end else begin
                        pe_sel <= first_sel(mod);
                        if (filtg_next == filtg_cnt) begin
                            filtg_idx <= '0;
                            ifg_idx   <= ifg_next;
                            state     <= (ifg_next == ifg_cnt) ? S_DONE : S_CLR;
                        end else begin
                            filtg_idx <= filtg_next;
                            state     <= S_DISPATCH;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign rst_dp   = (state == S_CLR);
    assign ifwen    = (state == S_LOAD);
    assign sel_addr = (state == S_DISPATCH) || (state == S_WAIT) || (state == S_ADVANCE);
    assign start_pe = (state == S_DISPATCH) ? pe_sel : '0;
    assign done_all = (state == S_DONE);

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: expected dispatches are queued with the
// stimulus and matched against start_pe / group indices as they appear.
module tb_pe_array_ctrl;

    localparam int PE = 3;
    localparam int CW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_ifg = '0;
    logic [CW-1:0] num_filtg = '0;
    logic          mode = 1'b0;
    logic          if_load_done = 1'b0;
    logic [PE-1:0] pe_done = '0;
    logic          busy, rst_dp, ifwen, sel_addr, mod, done_all, err;
    logic [PE-1:0] start_pe, pe_sel;
    logic [CW-1:0] ifg_idx, filtg_idx;

    pe_array_ctrl #(.PE_COUNT(PE), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .num_ifg(num_ifg), .num_filtg(num_filtg),
        .mode(mode), .if_load_done(if_load_done), .pe_done(pe_done), .busy(busy),
        .rst_dp(rst_dp), .ifwen(ifwen), .sel_addr(sel_addr), .start_pe(start_pe),
        .pe_sel(pe_sel), .ifg_idx(ifg_idx), .filtg_idx(filtg_idx), .mod(mod),
        .done_all(done_all), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PE-1:0] pe;
        logic [CW-1:0] ifg;
        logic [CW-1:0] filtg;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   checks = 0;
    int   errors = 0;
    int   n_rst_dp = 0, n_ifwen = 0, n_done = 0, n_start_pe = 0;
    logic ifwen_d = 1'b0;

    always @(negedge clk) begin
        if (rst_dp) n_rst_dp++;
        if (ifwen && !ifwen_d) n_ifwen++;
        ifwen_d = ifwen;
        if (done_all) n_done++;
        if (start_pe !== '0) begin
            n_start_pe++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected start_pe=%b ifg=%0d filtg=%0d", start_pe, ifg_idx, filtg_idx);
            end else begin
                sb_e = exp_q.pop_front();
                if ({start_pe, ifg_idx, filtg_idx} !== sb_e) begin
                    errors++;
                    $display("FAIL sb_dispatch got pe=%b ifg=%0d filtg=%0d want pe=%b ifg=%0d filtg=%0d",
                             start_pe, ifg_idx, filtg_idx, sb_e.pe, sb_e.ifg, sb_e.filtg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_rst_dp = 0; n_ifwen = 0; n_done = 0; n_start_pe = 0;
    endtask

    task automatic do_start(input logic m, input logic [CW-1:0] ni, input logic [CW-1:0] nf);
        mode = m; num_ifg = ni; num_filtg = nf; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, rst_dp} !== 2'b11) begin
            errors++; $display("FAIL start_to_rst_dp busy,rst_dp=%b want 11", {busy, rst_dp});
        end
    endtask

    task automatic load_ifmap(input int hold);
        int n = 0;
        while (ifwen !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (ifwen !== 1'b1 || sel_addr !== 1'b0) begin
            errors++; $display("FAIL load_phase ifwen=%b sel_addr=%b want 1 0", ifwen, sel_addr);
        end
        repeat (hold) tick();
        if_load_done = 1'b1;
        tick();
        if_load_done = 1'b0;
        checks++;
        if (start_pe === '0 || sel_addr !== 1'b1) begin
            errors++; $display("FAIL load_to_dispatch start_pe=%b sel_addr=%b want nonzero 1", start_pe, sel_addr);
        end
    endtask

    task automatic serve(input logic [PE-1:0] sel, input int lat);
        repeat (lat) tick();
        pe_done = sel;
        tick();
        pe_done = '0;
    endtask

    task automatic wait_dispatch(output int cyc);
        cyc = 0;
        while (start_pe === '0 && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (start_pe === '0) begin
            errors++; $display("FAIL dispatch_timeout start_pe=%b want nonzero", start_pe);
        end
    endtask

    task automatic expect_done();
        tick();
        checks++;
        if ({done_all, busy} !== 2'b11) begin
            errors++; $display("FAIL done_pulse done_all,busy=%b want 11", {done_all, busy});
        end
        tick();
        checks++;
        if ({done_all, busy} !== 2'b00) begin
            errors++; $display("FAIL back_to_idle done_all,busy=%b want 00", {done_all, busy});
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({busy, rst_dp, ifwen, sel_addr, start_pe, pe_sel, ifg_idx, filtg_idx, mod, done_all, err} !== '0) begin
            errors++; $display("FAIL reset_outputs busy=%b pe_sel=%b ifg=%0d filtg=%0d err=%b want all 0",
                               busy, pe_sel, ifg_idx, filtg_idx, err);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release busy=%b want 0", busy); end
    endtask

    task automatic test_parallel();
        int c;
        clear_counts();
        exp_q.push_back(exp_t'{3'b111, 8'd0, 8'd0});
        exp_q.push_back(exp_t'{3'b111, 8'd0, 8'd1});
        do_start(1'b0, 8'd1, 8'd2);
        load_ifmap(2);
        serve(3'b111, 5);
        wait_dispatch(c);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL par_done_to_start got %0d cycles want 1", c); end
        serve(3'b111, 5);
        expect_done();
        checks++;
        if ({n_rst_dp, n_ifwen, n_start_pe, n_done} !== {32'd1, 32'd1, 32'd2, 32'd1} || exp_q.size() != 0) begin
            errors++; $display("FAIL par_counts rst_dp=%0d ifwen=%0d start=%0d done=%0d left=%0d want 1 1 2 1 0",
                               n_rst_dp, n_ifwen, n_start_pe, n_done, exp_q.size());
        end
    endtask

    task automatic test_sequential();
        int c;
        clear_counts();
        exp_q.push_back(exp_t'{3'b001, 8'd0, 8'd0});
        exp_q.push_back(exp_t'{3'b010, 8'd0, 8'd0});
        exp_q.push_back(exp_t'{3'b100, 8'd0, 8'd0});
        do_start(1'b1, 8'd1, 8'd1);
        load_ifmap(0);
        checks++;
        if ({mod, pe_sel} !== 4'b1001) begin
            errors++; $display("FAIL seq_first_sel mod,pe_sel=%b want 1001", {mod, pe_sel});
        end
        serve(3'b001, 3);
        wait_dispatch(c);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL seq_step1 got %0d cycles want 1", c); end
        serve(3'b010, 2);
        wait_dispatch(c);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL seq_step2 got %0d cycles want 1", c); end
        serve(3'b100, 4);
        expect_done();
        checks++;
        if (n_start_pe != 3 || n_done != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL seq_counts start=%0d done=%0d left=%0d want 3 1 0", n_start_pe, n_done, exp_q.size());
        end
    endtask

    task automatic test_groups();
        clear_counts();
        exp_q.push_back(exp_t'{3'b111, 8'd0, 8'd0});
        exp_q.push_back(exp_t'{3'b111, 8'd1, 8'd0});
        do_start(1'b0, 8'd2, 8'd0);
        load_ifmap(1);
        serve(3'b111, 1);
        load_ifmap(0);
        serve(3'b111, 2);
        expect_done();
        checks++;
        if ({n_rst_dp, n_ifwen, n_start_pe, n_done} !== {32'd2, 32'd2, 32'd2, 32'd1} || exp_q.size() != 0 || err !== 1'b0) begin
            errors++; $display("FAIL grp_counts rst_dp=%0d ifwen=%0d start=%0d done=%0d left=%0d err=%b want 2 2 2 1 0 0",
                               n_rst_dp, n_ifwen, n_start_pe, n_done, exp_q.size(), err);
        end
    endtask

    task automatic test_stray();
        int c;
        clear_counts();
        exp_q.push_back(exp_t'{3'b001, 8'd0, 8'd0});
        exp_q.push_back(exp_t'{3'b010, 8'd0, 8'd0});
        exp_q.push_back(exp_t'{3'b100, 8'd0, 8'd0});
        do_start(1'b1, 8'd1, 8'd1);
        load_ifmap(0);
        tick();
        start = 1'b1; pe_done = 3'b100;
        tick();
        start = 1'b0; pe_done = '0;
        checks++;
        if ({busy, rst_dp, start_pe, pe_sel, sel_addr} !== {1'b1, 1'b0, 3'b000, 3'b001, 1'b1}) begin
            errors++; $display("FAIL stray_in_wait busy=%b rst_dp=%b start_pe=%b pe_sel=%b want 1 0 000 001",
                               busy, rst_dp, start_pe, pe_sel);
        end
        repeat (2) tick();
        pe_done = 3'b001;
        tick();
        pe_done = '0;
        wait_dispatch(c);
        serve(3'b010, 1);
        wait_dispatch(c);
        pe_done = 3'b100;
        tick();
        pe_done = '0;
        repeat (4) tick();
        checks++;
        if ({done_all, busy, pe_sel} !== {1'b0, 1'b1, 3'b100} || n_done != 0) begin
            errors++; $display("FAIL stray_not_counted done_all=%b busy=%b pe_sel=%b dones=%0d want 0 1 100 0",
                               done_all, busy, pe_sel, n_done);
        end
        pe_done = 3'b100;
        tick();
        pe_done = '0;
        expect_done();
        checks++;
        if (n_rst_dp != 1 || n_start_pe != 3 || exp_q.size() != 0) begin
            errors++; $display("FAIL stray_counts rst_dp=%0d start=%0d left=%0d want 1 3 0", n_rst_dp, n_start_pe, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        clear_counts();
        exp_q.push_back(exp_t'{3'b001, 8'd0, 8'd0});
        do_start(1'b1, 8'd1, 8'd3);
        load_ifmap(0);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, rst_dp, ifwen, sel_addr, start_pe, pe_sel, ifg_idx, filtg_idx, mod, done_all, err} !== '0) begin
            errors++; $display("FAIL async_reset busy=%b sel_addr=%b pe_sel=%b mod=%b want all 0", busy, sel_addr, pe_sel, mod);
        end
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy, pe_sel, mod, done_all} !== '0 || n_done != 0) begin
            errors++; $display("FAIL reset_idle busy=%b pe_sel=%b mod=%b dones=%0d want 0 000 0 0", busy, pe_sel, mod, n_done);
        end
        clear_counts();
        exp_q.push_back(exp_t'{3'b111, 8'd0, 8'd0});
        do_start(1'b0, 8'd1, 8'd1);
        load_ifmap(0);
        serve(3'b111, 2);
        expect_done();
        checks++;
        if (n_start_pe != 1 || n_done != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL rerun_counts start=%0d done=%0d left=%0d want 1 1 0", n_start_pe, n_done, exp_q.size());
        end
    endtask

`ifdef PE_TIMEOUT_EN
    task automatic test_timeout();
        int c = 0;
        exp_q.push_back(exp_t'{3'b111, 8'd0, 8'd0});
        do_start(1'b0, 8'd1, 8'd1);
        load_ifmap(0);
        while (done_all !== 1'b1 && c < 60) begin tick(); c++; end
        checks++;
        if (c !== 17 || err !== 1'b1) begin
            errors++; $display("FAIL timeout_done got %0d cycles err=%b want 17 1", c, err);
        end
        tick();
        checks++;
        if ({busy, err} !== 2'b01) begin errors++; $display("FAIL err_sticky busy,err=%b want 01", {busy, err}); end
        exp_q.push_back(exp_t'{3'b111, 8'd0, 8'd0});
        do_start(1'b0, 8'd1, 8'd1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear err=%b want 0", err); end
        load_ifmap(0);
        serve(3'b111, 1);
        expect_done();
    endtask
`endif

    initial begin
        test_reset();
        test_parallel();
        test_sequential();
        test_groups();
        test_stray();
        test_reset_mid_run();
`ifdef PE_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Parametrised top-level sequencer for the convolution PE array, driving a configurable number of PEs through ifmap-group and filter-group loops. It handles datapath reset, ifmap buffer load handshakes and per-PE start/done tracking. It supports parallel and one-hot sequential PE dispatch. It sits between the host start strobe and the PE datapath, and replaces external group counters with internal runtime-programmable ones.

## Interface
- PE_COUNT, 3, number of PEs controlled (≥1)
- CNT_W, 8, width of group counters and count inputs
- TIMEOUT, 1024, WAIT-state watchdog limit in cycles (used only with PE_TIMEOUT_EN)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  run request, sampled in IDLE only
- num_ifg  input  CNT_W  ifmap group count, latched at start; 0 treated as 1
- num_filtg  input  CNT_W  filter group count, latched at start; 0 treated as 1
- mode  input  1  latched at start; 0 = parallel dispatch, 1 = sequential one-hot dispatch
- if_load_done  input  1  ifmap buffer fill complete
- pe_done  input  PE_COUNT  per-PE completion pulses
- busy  output  1  high from the cycle after an accepted start through DONE
- rst_dp  output  1  one-cycle datapath clear
- ifwen  output  1  ifmap buffer write enable
- sel_addr  output  1  0 = loader addresses buffer, 1 = PEs address buffer
- start_pe  output  PE_COUNT  one-cycle per-PE start pulses
- pe_sel  output  PE_COUNT  one-hot current PE (mode 1); all ones in mode 0
- ifg_idx, filtg_idx  output  CNT_W  current group indices
- mod  output  1  latched mode, forwarded to PEs
- done_all  output  1  one-cycle completion pulse
- err  output  1  sticky timeout flag

## Operation
- States: IDLE, CLR, LOAD, DISPATCH, WAIT, ADVANCE, DONE.
- IDLE: start=1 latches num_ifg, num_filtg and mode. Clears both indices, sets pe_sel to bit 0 (mode 1) or all ones (mode 0), clears err, and moves to CLR. start is ignored in every other state.
- CLR: rst_dp=1 for one cycle, then LOAD.
- LOAD: ifwen=1, sel_addr=0. Leaves to DISPATCH in the cycle after if_load_done is sampled high.
- DISPATCH: start_pe = pe_sel for one cycle, sel_addr=1. Clears the sticky done vector for the selected PEs. Moves to WAIT.
- WAIT: ORs pe_done into the sticky done vector. Moves to ADVANCE when (sticky & pe_sel) == pe_sel. pe_done bits for unselected PEs are ignored.
- ADVANCE, mode 1, pe_sel not at MSB: rotate pe_sel left, go to DISPATCH.
- ADVANCE, otherwise: reset pe_sel and filtg_idx++. If filtg_idx reaches num_filtg it wraps to 0 and ifg_idx++, and the state goes to CLR (next ifmap group). Otherwise the state goes to DISPATCH.
- ADVANCE, ifg_idx reaching num_ifg: go to DONE.
- DONE: done_all=1 for one cycle, busy=1, then IDLE.
- Counter arithmetic is CNT_W bits, unsigned. A count of 0 behaves exactly as a count of 1.

## Timing
- Reset values: all outputs 0; pe_sel 0; state IDLE.
- Start to rst_dp: 1 cycle. busy rises in the same cycle as rst_dp.
- if_load_done to start_pe: 1 cycle.
- Last required pe_done to next start_pe: 2 cycles (WAIT→ADVANCE→DISPATCH).
- pe_done arriving in the DISPATCH cycle is dropped. PEs take at least 1 cycle.
- if_load_done outside LOAD is ignored.
- Reset asserted mid-run returns to IDLE immediately. No done_all is produced.

## Configuration
- PE_TIMEOUT_EN defined: a counter runs in WAIT and clears on entry to WAIT. Reaching TIMEOUT cycles sets err and forces DONE, so done_all still pulses. err stays set until the next accepted start.
- PE_TIMEOUT_EN undefined: no counter; err is tied to 0; WAIT waits indefinitely.

## Test plan
- Mode 0, PE_COUNT=3, num_ifg=1, num_filtg=2, PEs done 5 cycles after start: the bench sees 2 start_pe=3'b111 pulses, a single rst_dp, then done_all. filtg_idx steps 0→1.
- Mode 1, num_ifg=1, num_filtg=1: start_pe pulses 001, 010, 100 in order. Each pulse waits for the matching pe_done. done_all follows 2 cycles after the last pe_done.
- num_ifg=2, num_filtg=0: the bench sees 2 rst_dp pulses, 2 ifwen phases and 2 dispatches total. ifg_idx steps 0→1.
- start pulsed during WAIT and pe_done[2] pulsed while pe_sel=001: no state change, and the stray done is not counted.
- rst pulled low in WAIT, then released: all outputs are 0 and the state is IDLE. A new start runs normally.
- PE_TIMEOUT_EN, TIMEOUT=16, no pe_done: err=1 and done_all pulse 17 cycles after DISPATCH. err clears on the next start.
